// File: rtl/mms_pkg.sv
// rtl/mms_pkg.sv - shared MMS types: Sv32 PTE/VPN/PPN and TLB entry/state definitions
package mms_pkg;

  localparam int PTE_WD = 32;
  localparam int ASID_W = 9;
  localparam int VPN1_W = 10;
  localparam int VPN0_W = 10;
  localparam int PPN1_W = 12;
  localparam int PPN0_W = 10;

  typedef logic [VPN1_W+VPN0_W-1:0] vpn_t;
  typedef logic [PPN1_W+PPN0_W-1:0] ppn_t;

  typedef struct packed {
    logic [PPN1_W-1:0] ppn1;
    logic [PPN0_W-1:0] ppn0;
    logic [1:0]        rsw;
    logic              d;
    logic              a;
    logic              g;
    logic              u;
    logic              x;
    logic              w;
    logic              r;
    logic              v;
  } pte_t;

  // glb is the PTE global bit ("global" is a reserved word)
  typedef struct packed {
    logic              valid;
    logic [ASID_W-1:0] asid;
    logic [VPN1_W-1:0] vpn1;
    logic [VPN0_W-1:0] vpn0;
    logic [PPN1_W-1:0] ppn1;
    logic [PPN0_W-1:0] ppn0;
    logic              mega;
    logic              glb;
    logic              u;
    logic              x;
    logic              w;
    logic              r;
    logic              dirty;
    logic              accessed;
  } tlb_entry_t;

  typedef enum logic [1:0] {IDLE, WALK_REQ, WALK_WAIT} tlb_state_e;

endpackage

// File: rtl/mms_tlb_match.sv
// rtl/mms_tlb_match.sv - combinational TLB entry compare with lowest-index one-hot select
module mms_tlb_match
  import mms_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  tlb_entry_t [ENTRIES-1:0] entries,
  input  vpn_t                     vpn,
  input  logic [ASID_W-1:0]        asid,
  input  logic                     use_asid,
  input  logic                     use_vpn,
  input  logic                     flush_mode,
  output logic [ENTRIES-1:0]       match_vec,
  output logic [ENTRIES-1:0]       hit_oh,
  output logic                     hit_any
);

  // Lookup: a global entry matches any ASID. Flush: only non-global entries of that ASID.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_vec[i] = entries[i].valid
        && (!use_asid || (flush_mode ? (!entries[i].glb && entries[i].asid == asid)
                                     : (entries[i].glb || entries[i].asid == asid)))
        && (!use_vpn || (entries[i].vpn1 == vpn[VPN0_W +: VPN1_W]
                         && (entries[i].mega || entries[i].vpn0 == vpn[VPN0_W-1:0])));
    end
  end

  assign hit_oh  = match_vec & (~match_vec + ENTRIES'(1));
  assign hit_any = |match_vec;

endmodule

// File: rtl/mms_tlb_fa.sv
// rtl/mms_tlb_fa.sv - fully-associative Sv32 TLB with PTW refill; MMS_TLB_PERF_CNT_EN adds hit/miss counters
module mms_tlb_fa
  import mms_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ASID_WD = 9,
  parameter int VPN1_WD = 10,
  parameter int VPN0_WD = 10,
  parameter int PPN1_WD = 12,
  parameter int PPN0_WD = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [VPN1_WD+VPN0_WD-1:0] req_vpn,
  input  logic [ASID_WD-1:0]         req_asid,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic                       resp_fault,
  output logic [PPN1_WD+PPN0_WD-1:0] resp_ppn,
  output logic [3:0]                 resp_perm,
  output logic                       ptw_req_valid,
  input  logic                       ptw_req_ready,
  output logic [VPN1_WD+VPN0_WD-1:0] ptw_req_vpn,
  output logic [ASID_WD-1:0]         ptw_req_asid,
  input  logic                       ptw_resp_valid,
  input  logic [PTE_WD-1:0]          ptw_resp_pte,
  input  logic                       ptw_resp_level,
  input  logic                       ptw_resp_fault,
  input  logic                       flush_valid,
  input  logic                       flush_asid_en,
  input  logic [ASID_WD-1:0]         flush_asid,
  input  logic                       flush_vpn_en,
  input  logic [VPN1_WD+VPN0_WD-1:0] flush_vpn
`ifdef MMS_TLB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_hit_cnt,
  output logic [31:0]                perf_miss_cnt
`endif
);

  localparam int IDX_WD = $clog2(ENTRIES);

  tlb_entry_t [ENTRIES-1:0] tlb_q;
  tlb_state_e               state_q, state_d;
  logic [IDX_WD-1:0]        rr_ptr;
  vpn_t                     lat_vpn;
  logic [ASID_WD-1:0]       lat_asid;
  logic                     drop_q;

  logic [ENTRIES-1:0] lk_vec, lk_oh, fl_vec, fl_oh;
  logic               lk_hit, fl_any;
  tlb_entry_t         hit_entry, new_entry;
  pte_t               pte;
  logic               accept, walk_done, walk_fault, do_fill, have_inv;
  logic [IDX_WD-1:0]  inv_idx, victim;
  logic               unused_match;

  assign pte = pte_t'(ptw_resp_pte);

  mms_tlb_match #(.ENTRIES(ENTRIES)) u_lookup (
    .entries    (tlb_q),
    .vpn        (req_vpn),
    .asid       (req_asid),
    .use_asid   (1'b1),
    .use_vpn    (1'b1),
    .flush_mode (1'b0),
    .match_vec  (lk_vec),
    .hit_oh     (lk_oh),
    .hit_any    (lk_hit)
  );

  mms_tlb_match #(.ENTRIES(ENTRIES)) u_flush (
    .entries    (tlb_q),
    .vpn        (flush_vpn),
    .asid       (flush_asid),
    .use_asid   (flush_asid_en),
    .use_vpn    (flush_vpn_en),
    .flush_mode (1'b1),
    .match_vec  (fl_vec),
    .hit_oh     (fl_oh),
    .hit_any    (fl_any)
  );

  assign unused_match = ^{lk_vec, fl_oh, fl_any, pte.rsw, hit_entry};

  always_comb begin
    hit_entry = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lk_oh[i]) hit_entry = tlb_entry_t'(hit_entry | tlb_q[i]);
    end
  end

  // Victim: lowest-index invalid slot, otherwise the round-robin pointer
  always_comb begin
    have_inv = 1'b0;
    inv_idx  = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!tlb_q[i].valid) begin
        have_inv = 1'b1;
        inv_idx  = IDX_WD'(i);
      end
    end
    victim = have_inv ? inv_idx : rr_ptr;
  end

  assign accept     = req_valid && req_ready;
  assign walk_done  = (state_q == WALK_WAIT) && ptw_resp_valid;
  assign walk_fault = ptw_resp_fault || !pte.v || (!pte.r && pte.w)
                      || (ptw_resp_level && (pte.ppn0 != '0));
  assign do_fill    = walk_done && !walk_fault && !drop_q && !flush_valid;

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.asid     = lat_asid;
    new_entry.vpn1     = lat_vpn[VPN0_W +: VPN1_W];
    new_entry.vpn0     = lat_vpn[VPN0_W-1:0];
    new_entry.ppn1     = pte.ppn1;
    new_entry.ppn0     = pte.ppn0;
    new_entry.mega     = ptw_resp_level;
    new_entry.glb      = pte.g;
    new_entry.u        = pte.u;
    new_entry.x        = pte.x;
    new_entry.w        = pte.w;
    new_entry.r        = pte.r;
    new_entry.dirty    = pte.d;
    new_entry.accessed = pte.a;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = (state_q == IDLE) && !flush_valid;
    ptw_req_valid = (state_q == WALK_REQ);
    ptw_req_vpn   = lat_vpn;
    ptw_req_asid  = lat_asid;
    case (state_q)
      IDLE:      if (req_valid && !flush_valid && !lk_hit) state_d = WALK_REQ;
      WALK_REQ:  if (ptw_req_ready) state_d = WALK_WAIT;
      WALK_WAIT: if (ptw_resp_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lat_vpn  <= '0;
      lat_asid <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !lk_hit) begin
        lat_vpn  <= req_vpn;
        lat_asid <= req_asid;
      end
      if (state_d == IDLE) drop_q <= 1'b0;
      else if (flush_valid) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlb_q  <= '0;
      rr_ptr <= '0;
    end else if (flush_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (fl_vec[i]) tlb_q[i].valid <= 1'b0;
      end
    end else if (do_fill) begin
      tlb_q[victim] <= new_entry;
      if (!have_inv) rr_ptr <= rr_ptr + IDX_WD'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_fault <= 1'b0;
      resp_ppn   <= '0;
      resp_perm  <= '0;
    end else if (accept && lk_hit) begin
      resp_valid <= 1'b1;
      resp_hit   <= 1'b1;
      resp_fault <= 1'b0;
      resp_ppn   <= {hit_entry.ppn1, hit_entry.mega ? req_vpn[VPN0_WD-1:0] : hit_entry.ppn0};
      resp_perm  <= {hit_entry.u, hit_entry.x, hit_entry.w, hit_entry.r};
    end else if (walk_done) begin
      resp_valid <= 1'b1;
      resp_hit   <= 1'b0;
      resp_fault <= walk_fault;
      resp_ppn   <= walk_fault ? '0
                    : {pte.ppn1, ptw_resp_level ? lat_vpn[VPN0_WD-1:0] : pte.ppn0};
      resp_perm  <= walk_fault ? '0 : {pte.u, pte.x, pte.w, pte.r};
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_fault <= 1'b0;
      resp_ppn   <= '0;
      resp_perm  <= '0;
    end
  end

`ifdef MMS_TLB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (accept && lk_hit && perf_hit_cnt != '1) perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (accept && !lk_hit && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mms_tlb_fa.sv
// tb/tb_mms_tlb_fa.sv - directed and randomized bench for mms_tlb_fa against a behavioural TLB model
module tb_mms_tlb_fa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [19:0] req_vpn;
  logic [8:0]  req_asid;
  logic        resp_valid, resp_hit, resp_fault;
  logic [21:0] resp_ppn;
  logic [3:0]  resp_perm;
  logic        ptw_req_valid, ptw_req_ready;
  logic [19:0] ptw_req_vpn;
  logic [8:0]  ptw_req_asid;
  logic        ptw_resp_valid;
  logic [31:0] ptw_resp_pte;
  logic        ptw_resp_level, ptw_resp_fault;
  logic        flush_valid, flush_asid_en, flush_vpn_en;
  logic [8:0]  flush_asid;
  logic [19:0] flush_vpn;
`ifdef MMS_TLB_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  always #5 clk = ~clk;

  mms_tlb_fa dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_fault(resp_fault),
    .resp_ppn(resp_ppn), .resp_perm(resp_perm),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
    .ptw_req_vpn(ptw_req_vpn), .ptw_req_asid(ptw_req_asid),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_pte(ptw_resp_pte),
    .ptw_resp_level(ptw_resp_level), .ptw_resp_fault(ptw_resp_fault),
    .flush_valid(flush_valid), .flush_asid_en(flush_asid_en), .flush_asid(flush_asid),
    .flush_vpn_en(flush_vpn_en), .flush_vpn(flush_vpn)
`ifdef MMS_TLB_PERF_CNT_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference TLB contents: slot order mirrors fill order, rr is the eviction pointer
  bit          m_v[8];
  logic [8:0]  m_asid[8];
  logic [19:0] m_vpn[8];
  logic [21:0] m_ppn[8];
  bit          m_mega[8];
  bit          m_g[8];
  logic [3:0]  m_perm[8];
  int          rr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_pte(input logic [11:0] p1, input logic [9:0] p0, input logic [7:0] fl);
    return {p1, p0, 2'b00, fl};
  endfunction

  function automatic int m_find(input logic [19:0] vpn, input logic [8:0] asid);
    for (int i = 0; i < 8; i++) begin
      if (m_v[i] && (m_g[i] || m_asid[i] == asid) && m_vpn[i][19:10] == vpn[19:10]
          && (m_mega[i] || m_vpn[i][9:0] == vpn[9:0])) return i;
    end
    return -1;
  endfunction

  function automatic void m_fill(input logic [19:0] vpn, input logic [8:0] asid,
                                 input logic [31:0] pte, input logic lvl);
    int s = -1;
    for (int i = 0; i < 8; i++) if (!m_v[i] && s < 0) s = i;
    if (s < 0) begin
      s = rr;
      rr = (rr + 1) % 8;
    end
    m_v[s] = 1; m_asid[s] = asid; m_vpn[s] = vpn; m_ppn[s] = pte[31:10];
    m_mega[s] = lvl; m_g[s] = pte[5]; m_perm[s] = pte[4:1];
  endfunction

  function automatic void m_flush(input bit ae, input logic [8:0] a, input bit ve, input logic [19:0] v);
    for (int i = 0; i < 8; i++) begin
      if ((!ae || (!m_g[i] && m_asid[i] == a))
          && (!ve || (m_vpn[i][19:10] == v[19:10] && (m_mega[i] || m_vpn[i][9:0] == v[9:0]))))
        m_v[i] = 0;
    end
  endfunction

  task automatic lookup(input logic [19:0] vpn, input logic [8:0] asid, input logic [31:0] pte,
                        input logic lvl, input logic pf, input bit fmid);
    int idx, d;
    logic [21:0] eppn;
    logic [3:0]  eperm;
    logic        efault;
    idx = m_find(vpn, asid);
    @(negedge clk);
    req_valid = 1; req_vpn = vpn; req_asid = asid;
    #1 chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    if (idx >= 0) begin
      eppn = m_mega[idx] ? {m_ppn[idx][21:10], vpn[9:0]} : m_ppn[idx];
      chk("hit_valid", resp_valid, 1);
      chk("hit_flag", resp_hit, 1);
      chk("hit_fault", resp_fault, 0);
      chk("hit_ppn", resp_ppn, eppn);
      chk("hit_perm", resp_perm, m_perm[idx]);
    end else begin
      chk("miss_no_resp", resp_valid, 0);
      chk("ptw_req_valid", ptw_req_valid, 1);
      chk("ptw_req_vpn", ptw_req_vpn, vpn);
      chk("ptw_req_asid", ptw_req_asid, asid);
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge clk);
        chk("ptw_req_hold", ptw_req_valid, 1);
      end
      ptw_req_ready = 1;
      @(negedge clk);
      ptw_req_ready = 0;
      chk("ptw_req_done", ptw_req_valid, 0);
      d = $urandom_range(0, 2);
      repeat (d) begin
        @(negedge clk);
        chk("walk_wait_quiet", resp_valid, 0);
      end
      if (fmid) begin
        flush_valid = 1; flush_asid_en = 0; flush_vpn_en = 0;
        @(negedge clk);
        flush_valid = 0;
        m_flush(0, 0, 0, 0);
      end
      ptw_resp_valid = 1; ptw_resp_pte = pte; ptw_resp_level = lvl; ptw_resp_fault = pf;
      @(negedge clk);
      ptw_resp_valid = 0; ptw_resp_fault = 0;
      efault = pf | !pte[0] | (!pte[1] & pte[2]) | (lvl && pte[19:10] != 0);
      eppn   = efault ? 22'h0 : {pte[31:20], lvl ? vpn[9:0] : pte[19:10]};
      eperm  = efault ? 4'h0 : pte[4:1];
      chk("refill_valid", resp_valid, 1);
      chk("refill_hit", resp_hit, 0);
      chk("refill_fault", resp_fault, efault);
      chk("refill_ppn", resp_ppn, eppn);
      chk("refill_perm", resp_perm, eperm);
      if (!efault && !fmid) m_fill(vpn, asid, pte, lvl);
    end
    @(negedge clk);
    chk("resp_single_pulse", resp_valid, 0);
  endtask

  task automatic do_flush(input bit ae, input logic [8:0] a, input bit ve, input logic [19:0] v);
    @(negedge clk);
    flush_valid = 1; flush_asid_en = ae; flush_asid = a; flush_vpn_en = ve; flush_vpn = v;
    #1 chk("flush_blocks_ready", req_ready, 0);
    @(negedge clk);
    flush_valid = 0; flush_asid_en = 0; flush_vpn_en = 0;
    m_flush(ae, a, ve, v);
  endtask

  initial begin
    logic [19:0] pool[12];
    logic [31:0] pte;
    logic [7:0]  fl;
    logic [9:0]  p0;
    logic        lvl;

    rst_n = 0; req_valid = 0; req_vpn = 0; req_asid = 0; ptw_req_ready = 0;
    ptw_resp_valid = 0; ptw_resp_pte = 0; ptw_resp_level = 0; ptw_resp_fault = 0;
    flush_valid = 0; flush_asid_en = 0; flush_asid = 0; flush_vpn_en = 0; flush_vpn = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_resp_ppn", resp_ppn, 0);
    chk("rst_resp_perm", resp_perm, 0);
    chk("rst_ptw_req_valid", ptw_req_valid, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // Basic miss/refill then hit
    lookup(20'h12345, 9'd1, mk_pte(12'h002, 10'h2BC, 8'hCF), 0, 0, 0);
    lookup(20'h12345, 9'd1, 32'h0, 0, 0, 0);

    // Megapage and misaligned megapage
    lookup(20'h12000, 9'd1, mk_pte(12'h123, 10'h000, 8'hCF), 1, 0, 0);
    lookup(20'h123FF, 9'd1, 32'h0, 0, 0, 0);
    lookup(20'h0C000, 9'd1, mk_pte(12'h050, 10'h001, 8'hCF), 1, 0, 0);
    lookup(20'h0C000, 9'd1, mk_pte(12'h051, 10'h000, 8'hCB), 0, 0, 0);

    // Round-robin eviction once all 8 slots are full
    do_flush(0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      lookup(20'h40000 + 20'(i), 9'd1, mk_pte(12'h200, 10'(i), 8'hC7), 0, 0, 0);
    lookup(20'h40000, 9'd1, mk_pte(12'h300, 10'h000, 8'hC7), 0, 0, 0);
    lookup(20'h40002, 9'd1, 32'h0, 0, 0, 0);
    lookup(20'h40008, 9'd1, 32'h0, 0, 0, 0);

    // ASID isolation, global entries, qualified flushes
    do_flush(0, 0, 0, 0);
    lookup(20'h55555, 9'd1, mk_pte(12'h011, 10'h011, 8'hCF), 0, 0, 0);
    lookup(20'h55555, 9'd2, mk_pte(12'h022, 10'h022, 8'hCB), 0, 0, 0);
    lookup(20'h66666, 9'd1, mk_pte(12'h033, 10'h033, 8'hEF), 0, 0, 0);
    lookup(20'h66666, 9'd2, 32'h0, 0, 0, 0);
    do_flush(1, 9'd1, 0, 0);
    lookup(20'h66666, 9'd3, 32'h0, 0, 0, 0);
    lookup(20'h55555, 9'd2, 32'h0, 0, 0, 0);
    lookup(20'h55555, 9'd1, mk_pte(12'h044, 10'h044, 8'hDF), 0, 0, 0);
    do_flush(0, 0, 1, 20'h55555);
    lookup(20'h55555, 9'd2, mk_pte(12'h055, 10'h055, 8'hCF), 0, 0, 0);
    do_flush(0, 0, 0, 0);
    lookup(20'h66666, 9'd1, mk_pte(12'h066, 10'h066, 8'hCF), 0, 0, 0);

    // Flush during a walk drops the fill but still responds
    lookup(20'h77777, 9'd1, mk_pte(12'h077, 10'h077, 8'hCF), 0, 0, 1);
    lookup(20'h77777, 9'd1, mk_pte(12'h078, 10'h078, 8'hCF), 0, 0, 0);

    // Flush and request in the same cycle: request refused, nothing happens
    @(negedge clk);
    flush_valid = 1; req_valid = 1; req_vpn = 20'h77777; req_asid = 9'd1;
    #1 chk("flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush_valid = 0; req_valid = 0;
    m_flush(0, 0, 0, 0);
    repeat (3) begin
      chk("flush_req_no_resp", resp_valid, 0);
      chk("flush_req_no_walk", ptw_req_valid, 0);
      @(negedge clk);
    end

    // Stray walker response while idle is ignored
    ptw_resp_valid = 1; ptw_resp_pte = mk_pte(12'h111, 10'h111, 8'hCF);
    @(negedge clk);
    ptw_resp_valid = 0;
    chk("stray_ptw_resp", resp_valid, 0);
    chk("stray_ready", req_ready, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 12; i++) pool[i] = {10'h010 + 10'(i % 3), 10'(i / 3)};
    for (int n = 0; n < 90; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_flush(1'($urandom_range(0, 1)), 9'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)]);
      end else begin
        lvl = ($urandom_range(0, 3) == 0);
        p0  = 10'($urandom);
        if (lvl && $urandom_range(0, 3) != 0) p0 = 0;
        fl  = {2'b11, 1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 9) != 0)};
        pte = mk_pte(12'($urandom), p0, fl);
        lookup(pool[$urandom_range(0, 11)], 9'($urandom_range(1, 3)), pte, lvl,
               1'($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
